// File: rtl/tst_din_dgen_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tst_din_dgen_ctrl
// Brief    : Sequencer for the PRBS31 test-data generator in the tst_din path.
//            Issues seed-load / advance strobes to build framed bursts with
//            inter-frame gaps, honours downstream backpressure and produces a
//            last-sample flag aligned with the generator's registered output.
// Revision : 1.0 - initial release
// ============================================================================
module tst_din_dgen_ctrl #(
  parameter int LEN_W   = 16,
  parameter int NFR_W   = 16,
  parameter int GAP_W   = 8,
  parameter int GEN_LAT = 2
) (
  input  logic             clk,
  input  logic             arstn,
  input  logic             start,
  input  logic             stop,
  input  logic [LEN_W-1:0] cfg_frame_len,
  input  logic [NFR_W-1:0] cfg_num_frames,
  input  logic [GAP_W-1:0] cfg_gap,
  input  logic             cfg_reseed,
  input  logic             dst_rdy,
  output logic             gen_srst,
  output logic             gen_en,
  output logic             last_o,
  output logic             busy,
  output logic             done,
  output logic [NFR_W-1:0] frame_cnt
);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_SEED = 3'd1;
  localparam logic [2:0] c_RUN  = 3'd2;
  localparam logic [2:0] c_GAP  = 3'd3;
  localparam logic [2:0] c_DONE = 3'd4;

  localparam logic [LEN_W-1:0] c_LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [NFR_W-1:0] c_NFR_ONE = {{(NFR_W-1){1'b0}}, 1'b1};
  localparam logic [GAP_W-1:0] c_GAP_ONE = {{(GAP_W-1){1'b0}}, 1'b1};

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [LEN_W-1:0]   r_len;
  logic [NFR_W-1:0]   r_nfr;
  logic [GAP_W-1:0]   r_gap;
  logic               r_reseed;
  logic [LEN_W-1:0]   r_smp_cnt;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic [NFR_W-1:0]   r_frame_cnt;
  logic               r_stop_pend;
  logic [GEN_LAT-1:0] r_last_sr;

  logic               w_start_ok;
  logic               w_gen_en;
  logic               w_last_smp;
  logic               w_stop_any;
  logic [NFR_W-1:0]   w_frame_cnt_inc;
  logic               w_nfr_reached;
  logic               w_gap_end;

  // A zero-length frame or a start colliding with stop is refused outright.
  assign w_start_ok      = start & ~stop & (cfg_frame_len != '0);
  assign w_gen_en        = (r_state == c_RUN) & dst_rdy;
  assign w_last_smp      = w_gen_en & (r_smp_cnt == (r_len - c_LEN_ONE));
  // A stop arriving on the boundary cycle itself still ends the run there.
  assign w_stop_any      = r_stop_pend | stop;
  assign w_frame_cnt_inc = r_frame_cnt + c_NFR_ONE;
  assign w_nfr_reached   = (r_nfr != '0) && (w_frame_cnt_inc == r_nfr);
  assign w_gap_end       = (r_gap_cnt == (r_gap - c_GAP_ONE));

  // Next-state decision; frame boundaries are resolved on the last advance.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: if (w_start_ok) w_state_nxt = c_SEED;
      c_SEED: w_state_nxt = c_RUN;
      c_RUN: begin
        if (w_last_smp) begin
          if (w_nfr_reached || w_stop_any) w_state_nxt = c_DONE;
          else if (r_gap != '0)            w_state_nxt = c_GAP;
          else if (r_reseed)               w_state_nxt = c_SEED;
          else                             w_state_nxt = c_RUN;
        end
      end
      c_GAP: begin
        if (w_stop_any)     w_state_nxt = c_DONE;
        else if (w_gap_end) w_state_nxt = r_reseed ? c_SEED : c_RUN;
      end
      c_DONE:  w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) r_state <= c_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Configuration is captured once per run so mid-run cfg changes are inert.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_len    <= '0;
      r_nfr    <= '0;
      r_gap    <= '0;
      r_reseed <= 1'b0;
    end else if ((r_state == c_IDLE) && w_start_ok) begin
      r_len    <= cfg_frame_len;
      r_nfr    <= cfg_num_frames;
      r_gap    <= cfg_gap;
      r_reseed <= cfg_reseed;
    end
  end

  // In-frame sample counter: advances only on cycles that advance the generator.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_smp_cnt <= '0;
    end else if ((r_state == c_IDLE) && w_start_ok) begin
      r_smp_cnt <= '0;
    end else if (w_gen_en) begin
      if (w_last_smp) r_smp_cnt <= '0;
      else            r_smp_cnt <= r_smp_cnt + c_LEN_ONE;
    end
  end

  // Completed-frame counter; wraps silently in continuous mode.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      r_frame_cnt <= '0;
    end else if ((r_state == c_IDLE) && w_start_ok) begin
      r_frame_cnt <= '0;
    end else if (w_last_smp) begin
      r_frame_cnt <= w_frame_cnt_inc;
    end
  end

  // Gap counter runs only while in GAP and restarts from zero on every entry.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                r_gap_cnt <= '0;
    else if (r_state == c_GAP) r_gap_cnt <= r_gap_cnt + c_GAP_ONE;
    else                       r_gap_cnt <= '0;
  end

  // Stop requests outside an active run are dropped; inside they wait for a boundary.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn)                                        r_stop_pend <= 1'b0;
    else if ((r_state == c_IDLE) || (r_state == c_DONE)) r_stop_pend <= 1'b0;
    else if (stop)                                     r_stop_pend <= 1'b1;
  end

  // Last-sample marker delayed to line up with the generator's output valid.
  generate
    if (GEN_LAT == 1) begin : g_last_lat1
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_last_sr <= '0;
        else        r_last_sr <= w_last_smp;
      end
    end else begin : g_last_latn
      always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) r_last_sr <= '0;
        else        r_last_sr <= {r_last_sr[GEN_LAT-2:0], w_last_smp};
      end
    end
  endgenerate

  assign gen_srst  = (r_state == c_SEED);
  assign gen_en    = w_gen_en;
  assign last_o    = r_last_sr[GEN_LAT-1];
  assign busy      = (r_state != c_IDLE);
  assign done      = (r_state == c_DONE);
  assign frame_cnt = r_frame_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tst_din_dgen_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tst_din_dgen_ctrl
// Brief    : Scoreboard bench for tst_din_dgen_ctrl. Each run is turned into an
//            expected strobe sequence (seed / sample / done) from the frame
//            rules; a monitor pops and compares whenever the DUT strobes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tst_din_dgen_ctrl;

  localparam int LEN_W   = 16;
  localparam int NFR_W   = 16;
  localparam int GAP_W   = 8;
  localparam int GEN_LAT = 2;

  localparam int K_SEED = 0;
  localparam int K_SMP  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    bit last;
    int delta;
    int fcnt;
  } tok_t;

  tok_t sb[$];
  bit   exp_last[int];

  logic             clk = 1'b0;
  logic             arstn = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic [LEN_W-1:0] cfg_frame_len = '0;
  logic [NFR_W-1:0] cfg_num_frames = '0;
  logic [GAP_W-1:0] cfg_gap = '0;
  logic             cfg_reseed = 1'b0;
  logic             dst_rdy = 1'b0;
  logic             gen_srst;
  logic             gen_en;
  logic             last_o;
  logic             busy;
  logic             done;
  logic [NFR_W-1:0] frame_cnt;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int prev_cyc = 0;
  bit saw_stall = 1'b0;

  tst_din_dgen_ctrl #(
    .LEN_W(LEN_W), .NFR_W(NFR_W), .GAP_W(GAP_W), .GEN_LAT(GEN_LAT)
  ) dut (
    .clk(clk), .arstn(arstn), .start(start), .stop(stop),
    .cfg_frame_len(cfg_frame_len), .cfg_num_frames(cfg_num_frames),
    .cfg_gap(cfg_gap), .cfg_reseed(cfg_reseed), .dst_rdy(dst_rdy),
    .gen_srst(gen_srst), .gen_en(gen_en), .last_o(last_o), .busy(busy),
    .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void chk_ge(string name, int act, int lo);
    n_cmp++;
    if (act < lo) begin
      n_err++;
      $display("FAIL %s: got %0d, expected at least %0d (cycle %0d)", name, act, lo, cyc);
    end
  endfunction

  function automatic void push_tok(int kind, bit last, int delta, int fcnt);
    tok_t t;
    t.kind = kind; t.last = last; t.delta = delta; t.fcnt = fcnt;
    sb.push_back(t);
  endfunction

  // Reference: a run of nf frames is seed, then per frame len samples, gaps and
  // optional reseeds between frames, then done. delta = cycles since previous strobe.
  function automatic void push_run(int len, int nf, int gap, bit rs);
    push_tok(K_SEED, 1'b0, 1, 0);
    for (int f = 1; f <= nf; f++) begin
      for (int s = 0; s < len; s++)
        push_tok(K_SMP, s == len - 1, (s == 0 && f > 1 && !rs) ? gap + 1 : 1, f - 1);
      if (f < nf && rs) push_tok(K_SEED, 1'b0, gap + 1, f);
    end
    push_tok(K_DONE, 1'b0, 1, nf);
  endfunction

  // Monitor: compares every strobe the DUT presents against the scoreboard.
  always @(negedge clk) begin
    int   ntok;
    int   kind;
    tok_t t;
    if (arstn === 1'b1) begin
      if (exp_last.exists(cyc) || last_o === 1'b1) begin
        chk("last_o", int'(last_o), exp_last.exists(cyc) ? int'(exp_last[cyc]) : 0);
        if (exp_last.exists(cyc)) exp_last.delete(cyc);
      end
      ntok = int'(gen_srst) + int'(gen_en) + int'(done);
      if (ntok > 1) chk("single_strobe", ntok, 1);
      if (ntok != 0) begin
        kind = done ? K_DONE : (gen_srst ? K_SEED : K_SMP);
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_strobe: got kind %0d, expected none (cycle %0d)", kind, cyc);
        end else begin
          t = sb.pop_front();
          chk("strobe_kind", kind, t.kind);
          if (saw_stall) chk_ge("strobe_spacing", cyc - prev_cyc, t.delta);
          else           chk("strobe_spacing", cyc - prev_cyc, t.delta);
          chk("frame_cnt", int'(frame_cnt), t.fcnt);
          chk("busy_active", int'(busy), 1);
          if (kind == K_SMP) exp_last[cyc + GEN_LAT] = t.last;
        end
        prev_cyc  = cyc;
        saw_stall = 1'b0;
      end else if (dst_rdy !== 1'b1) begin
        saw_stall = 1'b1;
      end
    end
  end

  task automatic do_run(input int len, input int nfr, input int gap, input bit rs,
                        input int stopk, input int pct, input int abort_at,
                        input int sfrom, input int sto);
    int nen, rel, nf, ndone;
    bit got_done, stop_sent;
    nen = 0; rel = 0; got_done = 1'b0; stop_sent = 1'b0;
    nf = (nfr == 0) ? stopk : ((stopk != 0 && stopk < nfr) ? stopk : nfr);
    @(posedge clk); #1;
    cfg_frame_len  = LEN_W'(len);
    cfg_num_frames = NFR_W'(nfr);
    cfg_gap        = GAP_W'(gap);
    cfg_reseed     = rs;
    push_run(len, nf, gap, rs);
    start = 1'b1; stop = 1'b0; dst_rdy = 1'b1;
    prev_cyc = cyc; saw_stall = 1'b0;
    for (int i = 0; i < 3000 && !got_done; i++) begin
      @(negedge clk);
      if (gen_en === 1'b1) nen++;
      if (done === 1'b1) got_done = 1'b1;
      if (abort_at > 0 && nen >= abort_at) begin
        #2; arstn = 1'b0;
        sb.delete(); exp_last.delete();
        #1;
        chk("rst_gen_en", int'(gen_en), 0);
        chk("rst_gen_srst", int'(gen_srst), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_last_o", int'(last_o), 0);
        chk("rst_frame_cnt", int'(frame_cnt), 0);
        @(posedge clk); @(posedge clk); #3;
        arstn = 1'b1; start = 1'b0; stop = 1'b0;
        ndone = 0;
        repeat (5) begin @(negedge clk); if (done === 1'b1) ndone++; end
        chk("no_done_after_rst", ndone, 0);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0; rel++;
      // Scramble configuration mid-run; the DUT must keep its latched copy.
      cfg_frame_len  = LEN_W'($urandom_range(9));
      cfg_num_frames = NFR_W'($urandom_range(5));
      cfg_gap        = GAP_W'($urandom_range(5));
      cfg_reseed     = 1'($urandom_range(1));
      if (!got_done) begin
        if (rel >= sfrom && rel <= sto) dst_rdy = 1'b0;
        else if (pct >= 100)            dst_rdy = 1'b1;
        else                            dst_rdy = ($urandom_range(99) < pct);
        if (stopk > 0 && !stop_sent && nen == (stopk - 1) * len + 1) begin
          stop = 1'b1; stop_sent = 1'b1;
        end else if ($urandom_range(19) == 0) begin
          start = 1'b1;
        end
      end
    end
    if (!got_done) begin
      n_cmp++; n_err++;
      $display("FAIL run_timeout: got no done, expected done (cycle %0d)", cyc);
      @(negedge clk); #2; arstn = 1'b0;
      sb.delete(); exp_last.delete();
      @(posedge clk); #3; arstn = 1'b1;
    end else begin
      @(negedge clk);
      chk("busy_after_done", int'(busy), 0);
      repeat (2) @(posedge clk);
    end
  endtask

  initial begin
    int len, nfr, gap, stopk, pct;
    bit rs;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gen_srst", int'(gen_srst), 0);
    chk("reset_gen_en", int'(gen_en), 0);
    chk("reset_last_o", int'(last_o), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_frame_cnt", int'(frame_cnt), 0);
    arstn = 1'b1;
    repeat (2) @(posedge clk);

    do_run(4, 2, 3, 1'b0, 0, 100, 0, -1, -1);
    do_run(4, 2, 3, 1'b1, 0, 100, 0, -1, -1);
    do_run(8, 1, 0, 1'b0, 0, 100, 0, 4, 6);
    do_run(5, 0, 0, 1'b0, 3, 100, 0, -1, -1);
    do_run(6, 2, 1, 1'b0, 0, 100, 3, -1, -1);
    do_run(3, 1, 0, 1'b0, 0, 100, 0, -1, -1);

    // Refused starts: zero length, and start together with stop.
    @(posedge clk); #1;
    cfg_frame_len = '0; cfg_num_frames = NFR_W'(1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    cfg_frame_len = LEN_W'(4); start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("refused_busy", int'(busy), 0);
      chk("refused_gen_srst", int'(gen_srst), 0);
    end

    for (int r = 0; r < 25; r++) begin
      nfr = $urandom_range(3);
      gap = $urandom_range(3);
      rs  = 1'($urandom_range(1));
      pct = ($urandom_range(2) == 0) ? 100 : (($urandom_range(1) == 0) ? 70 : 40);
      if (nfr == 0)                    stopk = $urandom_range(3, 1);
      else if ($urandom_range(1) == 0) stopk = $urandom_range(nfr, 1);
      else                             stopk = 0;
      len = (stopk != 0) ? $urandom_range(6, 2) : $urandom_range(6, 1);
      do_run(len, nfr, gap, rs, stopk, pct, 0, -1, -1);
    end

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #900000;
    n_err++;
    $display("FAIL watchdog: got no end of test, expected finish before %0d cycles", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/tst_din_dgen_ctrl.md
Name: tst_din_dgen_ctrl

Overview:
- Sequencer for the PRBS31 test-data generator in the tst_din path.
- Drives the generator's seed-load (gen_srst) and advance (gen_en) strobes to build framed bursts: frames of cfg_frame_len samples, separated by cfg_gap idle cycles, repeated cfg_num_frames times or continuously.
- Respects downstream backpressure.
- Generates a last-sample flag aligned with the generator's registered output, which lags gen_en by 2 cycles.

Parameters:
- LEN_W, 16, width of cfg_frame_len and the in-frame sample counter.
- NFR_W, 16, width of cfg_num_frames and frame_cnt.
- GAP_W, 8, width of cfg_gap.
- GEN_LAT, 2, cycles from gen_en to the matching gen_vld; depth of the last-flag delay line.

Ports:
- clk  in  1  single clock.
- arstn  in  1  reset, asynchronous assert, active-low.
- start  in  1  one-cycle pulse; begins a run; honoured only in IDLE.
- stop  in  1  one-cycle pulse; graceful stop request.
- cfg_frame_len  in  LEN_W  samples per frame; 0 is illegal.
- cfg_num_frames  in  NFR_W  frames per run; 0 means continuous until stop.
- cfg_gap  in  GAP_W  idle cycles between frames; 0 means back-to-back.
- cfg_reseed  in  1  1 reloads the seed before every frame; 0 reloads the seed only at run start.
- dst_rdy  in  1  downstream can take at least GEN_LAT+1 more samples.
- gen_srst  out  1  seed-load strobe to the generator.
- gen_en  out  1  advance strobe to the generator.
- last_o  out  1  high on the final sample of a frame; aligned to the generator's vld_o.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a run ends.
- frame_cnt  out  NFR_W  completed frames in the current run.

Behaviour:
- Reset (arstn low): all outputs 0, FSM in IDLE, counters 0, last delay line cleared. Takes effect immediately and asynchronously; a run in progress is abandoned with no done pulse.
- start in IDLE latches cfg_*. start is ignored if cfg_frame_len==0, if simultaneous with stop, or outside IDLE.
- FSM states:
  - IDLE -> SEED on an accepted start; frame_cnt cleared.
  - SEED: gen_srst=1 for exactly 1 cycle, gen_en=0; -> RUN.
  - RUN: gen_en = dst_rdy. The sample counter increments on each cycle with gen_en=1.
    - On the gen_en cycle where sample counter == len-1: sample counter := 0 and frame_cnt += 1.
    - Next state: DONE if (nfr!=0 and frame_cnt+1==nfr) or a stop is pending; else GAP if gap!=0; else SEED if reseed; else RUN (back-to-back).
  - GAP: counts gap cycles with gen_en=0. A pending stop exits to DONE immediately. After the count: -> SEED if reseed, else RUN.
  - DONE: done=1 for 1 cycle; -> IDLE.
- stop handling:
  - A stop seen in SEED/RUN is held pending and takes effect at the frame boundary; the current frame always completes.
  - A stop seen in IDLE or DONE is dropped.
- dst_rdy low stalls RUN: gen_en=0 and counters hold. There is no timeout.
- gen_en is never high in SEED, GAP, DONE or IDLE. gen_srst and gen_en are never high together.
- last_o: the last-sample marker (gen_en & count==len-1) enters a GEN_LAT-stage shift register; last_o is its output. last_o therefore coincides with the generator vld_o of that sample.
- Pipeline drain: busy drops in IDLE, but up to GEN_LAT samples may still emerge afterwards. Consumers use the generator's vld_o, not busy.
- frame_cnt wraps modulo 2^NFR_W in continuous mode; the wrap is harmless.
- cfg_* changes during a run have no effect.

Test Plan:
- len=4, nfr=2, gap=3, reseed=0, dst_rdy=1, start -> gen_srst at cycle 1; gen_en cycles 2-5 and 9-12; last_o at cycles 7 and 14; done at cycle 13; frame_cnt=2.
- Same configuration with reseed=1 -> a second 1-cycle gen_srst at cycle 9; the second frame's data equals the first frame's data.
- len=8, nfr=1, dst_rdy low for cycles 4-6 -> exactly 8 gen_en pulses; count held during the stall; single last_o 2 cycles after the 8th gen_en.
- nfr=0, len=5, gap=0, stop pulsed mid-frame 3 -> frame 3 completes; done 1 cycle after its last gen_en; frame_cnt=3.
- arstn asserted mid-RUN -> outputs 0 immediately; no done. A start after release begins with SEED.
- start with cfg_frame_len=0, and start+stop in the same cycle -> stays IDLE; busy=0; no gen_srst.
